// File: rtl/tail_light_pkg.sv
// Shared definitions for the tail-light front end and sequencer.
package tail_light_pkg;

  // Request state seen by the sequencer
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LEFT  = 2'b01,
    ST_RIGHT = 2'b10,
    ST_FAULT = 2'b11
  } req_state_e;

  // 4 Hz step and 5 ms debounce at a 50 MHz clock
  localparam int unsigned DIV_DEFAULT = 12_500_000;
  localparam int unsigned DEB_DEFAULT = 250_000;

  // Map the debounced lever pair onto the request state it selects
  function automatic req_state_e decode_levers(input logic dl, input logic dr);
    case ({dl, dr})
      2'b10:   decode_levers = ST_LEFT;
      2'b01:   decode_levers = ST_RIGHT;
      2'b11:   decode_levers = ST_FAULT;
      default: decode_levers = ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/lever_debounce.sv
// Two-flop synchronizer followed by a debounce counter for one lever contact.
// The stable value only flips after DEB consecutive synchronized samples disagree.
module lever_debounce
  import tail_light_pkg::*;
#(
  parameter int unsigned DEB = DEB_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic lever_i,
  output logic stable_o
);

  localparam int CW = $clog2(DEB + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter clears while the sample agrees; the DEB-th disagreeing sample flips the value
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer and debounce state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= lever_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/turn_signal_conditioner.sv
// Turn-lever front end: debounced levers, step prescaler and request FSM.
// Requests only move on step boundaries so the sequencer sees them stable for a period.
module turn_signal_conditioner
  import tail_light_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT,
  parameter int unsigned DEB = DEB_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic lever_l,
  input  logic lever_r,
  output logic l_req,
  output logic r_req,
  output logic step,
  output logic fault
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic          dl, dr;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic          step_q, step_d;
  req_state_e    state_q, state_d;
  logic          l_req_q, l_req_d;
  logic          r_req_q, r_req_d;
  logic          fault_q, fault_d;

  lever_debounce #(.DEB(DEB)) u_deb_l (
    .clk      (clk),
    .reset    (reset),
    .lever_i  (lever_l),
    .stable_o (dl)
  );

  lever_debounce #(.DEB(DEB)) u_deb_r (
    .clk      (clk),
    .reset    (reset),
    .lever_i  (lever_r),
    .stable_o (dr)
  );

  // Prescaler wraps at DIV-1; the step pulse is registered from the terminal count
  always_comb begin
    step_d    = (pre_cnt_q == PRE_LAST);
    pre_cnt_d = (pre_cnt_q == PRE_LAST) ? '0 : pre_cnt_q + 1'b1;
  end

  // Prescaler and step registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt_q <= '0;
      step_q    <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      step_q    <= step_d;
    end
  end

  // Next request state sampled only on a step; outputs decode the next state so they register with it
  always_comb begin
    state_d = state_q;
    if (step_q) begin
      state_d = decode_levers(dl, dr);
    end
    l_req_d = (state_d == ST_LEFT);
    r_req_d = (state_d == ST_RIGHT);
    fault_d = (state_d == ST_FAULT);
  end

  // Request state and registered output decodes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      l_req_q <= 1'b0;
      r_req_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      l_req_q <= l_req_d;
      r_req_q <= r_req_d;
      fault_q <= fault_d;
    end
  end

  assign l_req = l_req_q;
  assign r_req = r_req_q;
  assign step  = step_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_turn_signal_conditioner.sv
// Bench for turn_signal_conditioner with DIV=4, DEB=3: directed scenarios plus
// randomized lever activity compared every cycle against a history-based model.
module tb_turn_signal_conditioner;

  localparam int DIV = 4;
  localparam int DEB = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic lever_l = 1'b0;
  logic lever_r = 1'b0;
  logic l_req, r_req, step, fault;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  turn_signal_conditioner #(.DIV(DIV), .DEB(DEB)) dut (
    .clk     (clk),
    .reset   (reset),
    .lever_l (lever_l),
    .lever_r (lever_r),
    .l_req   (l_req),
    .r_req   (r_req),
    .step    (step),
    .fault   (fault)
  );

  always #5 clk = ~clk;

  // Reference model: edge count since reset, raw lever history, and the
  // window of the most recent DEB synchronized samples for each lever.
  int m_e;
  bit m_step, m_l, m_r, m_f, m_dl, m_dr;
  bit rawl[$];
  bit rawr[$];
  bit sql[$];
  bit sqr[$];
  bit sl, sr, difl, difr;

  always @(posedge clk) begin
    if (reset) begin
      m_e = 0;
      m_step = 0; m_l = 0; m_r = 0; m_f = 0; m_dl = 0; m_dr = 0;
      rawl.delete(); rawr.delete(); sql.delete(); sqr.delete();
    end else begin
      if (m_step) begin
        m_l = m_dl && !m_dr;
        m_r = m_dr && !m_dl;
        m_f = m_dl && m_dr;
      end
      m_e = m_e + 1;
      m_step = (m_e % DIV) == 0;
      rawl.push_back(lever_l);
      rawr.push_back(lever_r);
      if (rawl.size() > 3) void'(rawl.pop_front());
      if (rawr.size() > 3) void'(rawr.pop_front());
      sl = (rawl.size() == 3) ? rawl[0] : 1'b0;
      sr = (rawr.size() == 3) ? rawr[0] : 1'b0;
      sql.push_back(sl);
      sqr.push_back(sr);
      if (sql.size() > DEB) void'(sql.pop_front());
      if (sqr.size() > DEB) void'(sqr.pop_front());
      difl = (sql.size() == DEB);
      foreach (sql[k]) if (sql[k] == m_dl) difl = 0;
      difr = (sqr.size() == DEB);
      foreach (sqr[k]) if (sqr[k] == m_dr) difr = 0;
      if (difl) m_dl = !m_dl;
      if (difr) m_dr = !m_dr;
    end
  end

  // Cycle-by-cycle scoreboard against the model
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (step !== m_step) begin
        n_fail++;
        $display("FAIL model_step t=%0t: got %b expected %b", $time, step, m_step);
      end
      n_checks++;
      if (l_req !== m_l) begin
        n_fail++;
        $display("FAIL model_l_req t=%0t: got %b expected %b", $time, l_req, m_l);
      end
      n_checks++;
      if (r_req !== m_r) begin
        n_fail++;
        $display("FAIL model_r_req t=%0t: got %b expected %b", $time, r_req, m_r);
      end
      n_checks++;
      if (fault !== m_f) begin
        n_fail++;
        $display("FAIL model_fault t=%0t: got %b expected %b", $time, fault, m_f);
      end
      n_checks++;
      if (l_req === 1'b1 && r_req === 1'b1) begin
        n_fail++;
        $display("FAIL exclusive t=%0t: got l_req=%b r_req=%b expected not both", $time, l_req, r_req);
      end
    end
  end

  // Drive reset for two cycles with levers low; returns on the negedge where reset drops
  task automatic do_reset();
    reset   = 1'b1;
    lever_l = 1'b0;
    lever_r = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({l_req, r_req, step, fault} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0000", {l_req, r_req, step, fault});
    end
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (step !== ((i % DIV) == 0)) begin
        n_fail++;
        $display("FAIL reset_step_period cycle %0d: got %b expected %b", i, step, (i % DIV) == 0);
      end
    end
  endtask

  task automatic test_clean_left();
    do_reset();
    @(negedge clk);
    lever_l = 1'b1;
    for (int i = 2; i <= 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (l_req !== (i >= 9)) begin
        n_fail++;
        $display("FAIL clean_left_l_req cycle %0d: got %b expected %b", i, l_req, i >= 9);
      end
      n_checks++;
      if (r_req !== 1'b0) begin
        n_fail++;
        $display("FAIL clean_left_r_req cycle %0d: got %b expected 0", i, r_req);
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int j = 0; j <= 18; j++) begin
      lever_r = (j < 8) ? (((j / 2) % 2) == 0) : 1'b1;
      @(negedge clk);
      n_checks++;
      if (r_req !== ((j + 1) >= 17)) begin
        n_fail++;
        $display("FAIL bounce_r_req cycle %0d: got %b expected %b", j + 1, r_req, (j + 1) >= 17);
      end
    end
  endtask

  task automatic test_both_levers();
    do_reset();
    lever_l = 1'b1;
    lever_r = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      n_checks++;
      if (fault !== (i >= 9 && i < 17)) begin
        n_fail++;
        $display("FAIL both_fault cycle %0d: got %b expected %b", i, fault, i >= 9 && i < 17);
      end
      n_checks++;
      if (l_req !== (i >= 17)) begin
        n_fail++;
        $display("FAIL both_l_req cycle %0d: got %b expected %b", i, l_req, i >= 17);
      end
      n_checks++;
      if (r_req !== 1'b0) begin
        n_fail++;
        $display("FAIL both_r_req cycle %0d: got %b expected 0", i, r_req);
      end
      if (i == 9) lever_r = 1'b0;
    end
  endtask

  // Lever rises right after reset so dl flips on the edge that samples step
  task automatic test_step_alignment();
    do_reset();
    lever_l = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 4) begin
        n_checks++;
        if (step !== 1'b1) begin
          n_fail++;
          $display("FAIL align_step cycle %0d: got %b expected 1", i, step);
        end
      end
      n_checks++;
      if (l_req !== (i >= 9)) begin
        n_fail++;
        $display("FAIL align_l_req cycle %0d: got %b expected %b", i, l_req, i >= 9);
      end
    end
  endtask

  // Starts with l_req high and the left lever held
  task automatic test_mid_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({l_req, step, fault} !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_clear: got l_req/step/fault %b expected 000", {l_req, step, fault});
    end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (l_req !== (i >= 9)) begin
        n_fail++;
        $display("FAIL midreset_l_req cycle %0d: got %b expected %b", i, l_req, i >= 9);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    do_reset();
    for (int s = 0; s < 80; s++) begin
      lever_l = 1'($urandom_range(0, 1));
      lever_r = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 12);
      if ($urandom_range(0, 24) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      repeat (hold) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_clean_left();
    test_bounce();
    test_both_levers();
    test_step_alignment();
    test_mid_reset();
    test_random();
    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/turn_signal_conditioner.md
# turn_signal_conditioner

Front-end stage for the tail-light sequencer. It synchronizes and debounces the raw left and right turn-lever contacts, and resolves illegal lever combinations. It also generates the slow sequencer step tick, so the sequencer's L/R inputs are clean, mutually exclusive and change only on step boundaries. The sequencer consumes `l_req`, `r_req` and `step`, and advances one lamp state per `step` pulse.

## Interface
- `DIV`, default 12_500_000: step prescaler period in clk cycles (4 Hz at 50 MHz); legal range ≥ 2.
- `DEB`, default 250_000: debounce window in clk cycles (5 ms at 50 MHz); legal range ≥ 1.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high; clock clk.
- `lever_l`  in  1  raw left lever contact, asynchronous, may bounce.
- `lever_r`  in  1  raw right lever contact, asynchronous, may bounce.
- `l_req`  out  1  registered left request to the sequencer.
- `r_req`  out  1  registered right request to the sequencer.
- `step`  out  1  one-cycle pulse every `DIV` cycles; sequencer advance enable.
- `fault`  out  1  registered; both levers are stably closed.

## Operation
- Each lever channel:
  - 2-flop synchronizer feeds a debounce counter of width `$clog2(DEB+1)`.
  - The counter clears whenever the synchronized sample equals the stable value.
  - Otherwise it increments. The sample that brings it to `DEB` flips the stable value and clears the counter.
  - Glitches shorter than `DEB` cycles are therefore rejected.
- Prescaler:
  - Width `$clog2(DIV)`; counts 0..DIV-1 and wraps to 0.
  - `step` = (count == DIV-1), registered so it is high exactly one cycle per period.
- Request FSM has states IDLE, LEFT, RIGHT, FAULT. It updates only in a cycle where `step` is high; otherwise it holds.
- Next state from debounced (dl, dr):
  - 00 → IDLE
  - 10 → LEFT
  - 01 → RIGHT
  - 11 → FAULT
- Any state may reach any state on a step.
- Outputs are registered decodes of the state:
  - `l_req` = LEFT
  - `r_req` = RIGHT
  - `fault` = FAULT
- `l_req` and `r_req` are never high together.
- In FAULT both requests are 0, so the sequencer idles.

## Timing
- Reset values:
  - `l_req`, `r_req`, `step`, `fault`: 0.
  - State IDLE.
  - All synchronizer flops, debounced values and counters: 0.
- Reset asserted mid-operation:
  - Next edge forces all of the above to their reset values.
  - Any partially counted debounce is discarded.
  - The prescaler restarts, so the first `step` occurs exactly `DIV` cycles after the first edge with reset low.
- Lever to debounced latency: 2 synchronizer edges + `DEB` edges. A clean edge is reflected in dl/dr after `DEB+2` edges.
- Debounced to request: on the next `step`, registered.
  - The request is visible in the cycle after the edge where `step` was sampled high.
  - Worst-case total latency is `DEB+2+DIV+1` cycles.
- `l_req`, `r_req` and `fault` change only on the edge that samples `step` high. The sequencer sees them stable for a full step period.
- Simultaneous events:
  - A debounced value flipping on the same edge that samples `step` high is not seen until the next step.
  - The FSM uses the pre-edge registered debounced values.
- `DEB` = 1: any synchronized change that persists one cycle is accepted.

## Structure
- Shared package `tail_light_pkg`:
  - 2-bit request-state encoding: IDLE=00, LEFT=01, RIGHT=10, FAULT=11.
  - Default `DIV`/`DEB` constants, shared with the sequencer's top level.
- Sub-module `lever_debounce`: synchronizer plus debounce counter, parameter `DEB`. Instantiated once per lever.
- Prescaler and FSM live in the top module.

## Test plan
All scenarios use `DIV`=4, `DEB`=3.

- **Reset:** hold `reset` 2 cycles with levers low → all outputs 0; first `step` pulse exactly 4 cycles after `reset` falls, then every 4 cycles.
- **Clean left:** `lever_l` rises and stays high → dl high after 5 edges; `l_req` rises the cycle after the next `step`; `r_req`=0 throughout.
- **Bounce:** `lever_r` toggles 1,0,1,0 with 2-cycle pulses, then holds high → no change to dr until 5 edges after the final rise; `r_req` follows on the next `step`.
- **Both levers:** both held high → `fault`=1, `l_req`=`r_req`=0 after the next `step`; release `lever_r` → `l_req`=1, `fault`=0 one step after dr falls.
- **Mid-operation reset:** `l_req`=1, pulse `reset` for 1 cycle → `l_req`=0 the next cycle; with the lever still high, `l_req` reasserts on the first `step` after dl resettles (5 edges).
- **Step alignment:** change `lever_l` so dl flips on the edge sampling `step` → `l_req` unchanged until the following `step`, 4 cycles later.
